// File: rtl/nibble_serial_addsub_ctrl.sv
// nibble_serial_addsub_ctrl
// Wide unsigned add/subtract built from one 4-bit add/sub slice, one nibble
// per clock, LSB first. Subtract returns |A-B| plus a sign flag; the operands
// are swapped in LOAD so the slice always computes larger minus smaller.
//
// Handshake: start is a request pulse sampled only in IDLE (ignored, not
// queued, while busy). busy is high from LOAD through DONE. done is a
// one-cycle pulse in DONE, when out_s/out_cy/sign0 are valid. These outputs
// then hold until the LOAD of the next accepted request.

// 4-bit ripple add slice: {cout,sum} = a + b + cin.
module addsub4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] total;

  // Plain 5-bit addition; the caller pre-inverts b for subtract.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    sum   = total[3:0];
    cout  = total[4];
  end

endmodule

module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   out_s,
  output logic                   out_cy,
  output logic                   sign0
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  logic [1:0]       state_q,  state_d;
  logic [W-1:0]     opa_q,    opa_d;
  logic [W-1:0]     opb_q,    opb_d;
  logic             op_q,     op_d;
  logic             carry_q,  carry_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [W-1:0]     out_s_q,  out_s_d;
  logic             out_cy_q, out_cy_d;
  logic             sign0_q,  sign0_d;

  // Slice wiring: current nibble of each operand, b inverted for subtract.
  logic [IDX_W+1:0] nib_shift;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  // Select the nibble addressed by the index register.
  always_comb begin
    nib_shift = {idx_q, 2'b00};
    slice_a   = 4'(opa_q >> nib_shift);
    slice_b   = 4'(opb_q >> nib_shift) ^ {4{op_q}};
  end

  addsub4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state and datapath updates for the IDLE/LOAD/RUN/DONE sequence.
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    out_s_d  = out_s_q;
    out_cy_d = out_cy_q;
    sign0_d  = sign0_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Capture raw operands; ordering is decided in LOAD.
          opa_d   = in_a;
          opb_d   = in_b;
          op_d    = op;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (op_q && (opa_q < opb_q)) begin
          // Negative difference: compute B-A and flag the sign.
          opa_d   = opb_q;
          opb_d   = opa_q;
          sign0_d = 1'b0;
        end else begin
          sign0_d = 1'b1;
        end
        // Carry-in of 1 supplies the +1 of the two's complement on subtract.
        carry_d  = op_q;
        idx_d    = '0;
        out_s_d  = '0;
        out_cy_d = 1'b0;
        state_d  = S_RUN;
      end

      S_RUN: begin
        out_s_d = (out_s_q & ~(W'(4'hF) << nib_shift))
                | (W'(slice_sum) << nib_shift);
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          // The subtract end-carry is always 1 after the swap; drop it.
          out_cy_d = op_q ? 1'b0 : slice_cout;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous abort on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      out_s_q  <= '0;
      out_cy_q <= 1'b0;
      sign0_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      out_s_q  <= out_s_d;
      out_cy_q <= out_cy_d;
      sign0_q  <= sign0_d;
    end
  end

  // Outputs decode directly from registers.
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    out_s  = out_s_q;
    out_cy = out_cy_q;
    sign0  = sign0_q;
  end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Bench for nibble_serial_addsub_ctrl (NIBBLES=4): directed operations with
// hand-computed results, plus an arithmetic model checked on every cycle.
module tb_nibble_serial_addsub_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] out_s;
  logic         out_cy;
  logic         sign0;

  always #5 clk = ~clk;

  nibble_serial_addsub_ctrl #(.NIBBLES(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .in_a   (in_a),
    .in_b   (in_b),
    .busy   (busy),
    .done   (done),
    .out_s  (out_s),
    .out_cy (out_cy),
    .sign0  (sign0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Tracks the edge at which a request is accepted; the result is plain
  // arithmetic on the captured operands. Done appears N+1 edges after
  // acceptance, and the next request can be taken N+3 edges after it.
  int           cyc = 0;
  int           acc = 0;
  bit           fl  = 1'b0;
  logic [W-1:0] m_s = '0;
  logic         m_cy = 1'b0;
  logic         m_sign = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fl     = 1'b0;
      m_s    = '0;
      m_cy   = 1'b0;
      m_sign = 1'b1;
    end else begin
      cyc++;
      if (start && (!fl || (cyc - acc) >= N + 3)) begin
        logic [W:0] sum;
        fl  = 1'b1;
        acc = cyc;
        if (!op) begin
          sum    = {1'b0, in_a} + {1'b0, in_b};
          m_s    = sum[W-1:0];
          m_cy   = sum[W];
          m_sign = 1'b1;
        end else if (in_a >= in_b) begin
          m_s    = in_a - in_b;
          m_cy   = 1'b0;
          m_sign = 1'b1;
        end else begin
          m_s    = in_b - in_a;
          m_cy   = 1'b0;
          m_sign = 1'b0;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_out_s", 32'(out_s), 32'd0);
      chk("rst_sign0", 32'(sign0), 32'd1);
    end else begin
      int  d;
      bit  eb;
      bit  ed;
      d  = fl ? (cyc - acc) : 1000;
      eb = fl && (d <= N + 1);
      ed = fl && (d == N + 1);
      chk("cyc_busy", 32'(busy), 32'(eb));
      chk("cyc_done", 32'(done), 32'(ed));
      if (!eb || ed) begin
        chk("cyc_out_s", 32'(out_s), 32'(m_s));
        chk("cyc_out_cy", 32'(out_cy), 32'(m_cy));
        chk("cyc_sign0", 32'(sign0), 32'(m_sign));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one request from IDLE, scramble inputs afterwards, wait for done
  // and check latency, busy length and the hand-computed result.
  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic o, input logic [W-1:0] exp_s, input logic exp_cy,
                       input logic exp_sign);
    int lat;
    int busy_cnt;
    @(negedge clk);
    in_a  = a;
    in_b  = b;
    op    = o;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_a  = ~a;
    in_b  = a ^ b;
    op    = ~o;
    lat = 1;
    busy_cnt = (busy && !done) ? 1 : 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
      if (busy && !done) busy_cnt++;
    end
    chk({nm, "_done_seen"}, 32'(done), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'd6);
    chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd5);
    chk({nm, "_out_s"}, 32'(out_s), 32'(exp_s));
    chk({nm, "_out_cy"}, 32'(out_cy), 32'(exp_cy));
    chk({nm, "_sign0"}, 32'(sign0), 32'(exp_sign));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ndone;
    #2;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_out_s", 32'(out_s), 32'd0);
    chk("reset_out_cy", 32'(out_cy), 32'd0);
    chk("reset_sign0", 32'(sign0), 32'd1);

    do_op("add_basic",    16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b1);
    do_op("add_overflow", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_op("add_msb",      16'h8000, 16'h8001, 1'b0, 16'h0001, 1'b1, 1'b1);
    do_op("sub_neg",      16'h0005, 16'h0009, 1'b1, 16'h0004, 1'b0, 1'b0);
    do_op("sub_borrow",   16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b0, 1'b1);
    do_op("sub_equal",    16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b0, 1'b1);
    do_op("sub_neg_wide", 16'h0001, 16'hFFFF, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // start re-issued during RUN must be ignored.
    @(negedge clk);
    in_a = 16'h0101; in_b = 16'h0202; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    in_a = 16'h7777; in_b = 16'h9999; op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("ignore_out_s", 32'(out_s), 32'h0303);
        chk("ignore_sign0", 32'(sign0), 32'd1);
      end
    end
    chk("ignore_single_done", 32'(ndone), 32'd1);

    // Asynchronous reset in mid-RUN with nibble index 2.
    @(negedge clk);
    in_a = 16'h1111; in_b = 16'h2222; op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_out_s", 32'(out_s), 32'd0);
    chk("abort_out_cy", 32'(out_cy), 32'd0);
    chk("abort_sign0", 32'(sign0), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;

    do_op("after_reset", 16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 1'b1);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
